// File: rtl/memory_read_data_queue_pkg.sv
// Shared types and sizing constants for the memory read data queue.
// The AXI4 read-channel sizing lives here so every file agrees on widths.
package memory_read_data_queue_pkg;

  localparam int MEMORY_AXI4_READ_ID_NUM    = 4;
  localparam int MEMORY_AXI4_READ_ID_WIDTH  = 2;
  localparam int MEMORY_AXI4_BURST_BEAT_NUM = 2;
  localparam int MEMORY_AXI4_DATA_BIT_NUM   = 64;
  localparam int MEMORY_ENTRY_BIT_NUM       = 128;

  typedef logic [MEMORY_ENTRY_BIT_NUM-1:0] MemoryEntryDataPath;

  typedef enum logic [1:0] {
    ENTRY_FREE,
    ENTRY_PENDING,
    ENTRY_FILLING,
    ENTRY_DONE
  } entry_state_t;

  // A pointer or counter into n slots, never narrower than one bit.
  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_read_data_queue_if.sv
// Bus bundle for the read data queue: ID allocation, AXI4 R channel,
// in-order response delivery, and status flags.
import memory_read_data_queue_pkg::*;

interface memory_read_data_queue_if #(
  parameter int ID_W = MEMORY_AXI4_READ_ID_WIDTH,
  parameter int DW   = MEMORY_AXI4_DATA_BIT_NUM
) ();
  logic               allocReq;
  logic               allocAck;
  logic [ID_W-1:0]    allocId;
  logic               rvalid;
  logic [ID_W-1:0]    rid;
  logic [DW-1:0]      rdata;
  logic               rlast;
  logic               rready;
  logic               respValid;
  logic               respReady;
  MemoryEntryDataPath respData;
  logic [ID_W-1:0]    respId;
  logic               full;
  logic               empty;
  logic               protocolError;

  modport slave (
    input  allocReq, rvalid, rid, rdata, rlast, respReady,
    output allocAck, allocId, rready, respValid, respData, respId,
           full, empty, protocolError
  );

  modport master (
    output allocReq, rvalid, rid, rdata, rlast, respReady,
    input  allocAck, allocId, rready, respValid, respData, respId,
           full, empty, protocolError
  );
endinterface

// File: rtl/memory_read_data_queue_pointer.sv
// Circular head/tail pointer pair with occupancy count; push is refused
// when full and pop when empty, both judged on the pre-edge count.
import memory_read_data_queue_pkg::*;

module QueuePointer #(
  parameter int SIZE       = 4,
  parameter int INIT_HEAD  = 0,
  parameter int INIT_TAIL  = 0,
  parameter int INIT_COUNT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  output logic [ptrWidth(SIZE)-1:0] head,
  output logic [ptrWidth(SIZE)-1:0] tail,
  output logic                      full,
  output logic                      empty
);
  localparam int PW = ptrWidth(SIZE);
  localparam int CW = $clog2(SIZE + 1);

  logic [CW-1:0] count;
  logic          doPush;
  logic          doPop;

  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign full   = (count == CW'(SIZE));
  assign empty  = (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= PW'(INIT_HEAD);
      tail  <= PW'(INIT_TAIL);
      count <= CW'(INIT_COUNT);
    end else begin
      if (doPush) tail <= (tail == PW'(SIZE - 1)) ? '0 : tail + PW'(1);
      if (doPop)  head <= (head == PW'(SIZE - 1)) ? '0 : head + PW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/memory_read_data_queue.sv
// Reorders AXI4 read bursts that complete out of order across IDs and
// hands whole entries to the cache strictly in allocation order.
import memory_read_data_queue_pkg::*;

module memory_read_data_queue #(
  parameter int ID_NUM   = MEMORY_AXI4_READ_ID_NUM,
  parameter int BEAT_NUM = MEMORY_AXI4_BURST_BEAT_NUM,
  parameter int DW       = MEMORY_AXI4_DATA_BIT_NUM
) (
  input logic                   clk,
  input logic                   rst,
  memory_read_data_queue_if.slave bus
);
  localparam int ID_W    = ptrWidth(ID_NUM);
  localparam int BEAT_W  = ptrWidth(BEAT_NUM);
  localparam int ENTRY_W = BEAT_NUM * DW;

  if (ENTRY_W != MEMORY_ENTRY_BIT_NUM) begin : gEntryWidthCheck
    $error("entry width BEAT_NUM*DW must equal MEMORY_ENTRY_BIT_NUM");
  end

  entry_state_t        state     [ID_NUM];
  logic [BEAT_W-1:0]   beatCnt   [ID_NUM];
  logic [ENTRY_W-1:0]  entryData [ID_NUM];

  logic [ID_W-1:0]     head;
  logic [ID_W-1:0]     tail;
  logic                full;
  logic                empty;
  logic                rreadyQ;
  logic                errorQ;
  logic                doAlloc;
  logic                doPop;
  logic                respValid;
  logic                beatFire;
  logic                beatLive;
  logic                beatLast;
  logic                beatOk;
  logic                beatBad;
  logic [BEAT_W-1:0]   beatIdx;

  assign respValid = (state[head] == ENTRY_DONE);
  assign doAlloc   = bus.allocReq && !full;
  assign doPop     = respValid && bus.respReady;

  QueuePointer #(
    .SIZE(ID_NUM), .INIT_HEAD(0), .INIT_TAIL(0), .INIT_COUNT(0)
  ) uPointer (
    .clk   (clk),
    .rst   (rst),
    .push  (doAlloc),
    .pop   (doPop),
    .head  (head),
    .tail  (tail),
    .full  (full),
    .empty (empty)
  );

  // A beat is kept only if its ID is mid-burst and rlast matches the final slot.
  always_comb begin
    beatIdx  = beatCnt[bus.rid];
    beatLast = (beatIdx == BEAT_W'(BEAT_NUM - 1));
    beatFire = bus.rvalid && rreadyQ;
    beatLive = (state[bus.rid] == ENTRY_PENDING) || (state[bus.rid] == ENTRY_FILLING);
    beatOk   = beatFire && beatLive && (bus.rlast == beatLast);
    beatBad  = beatFire && !(beatLive && (bus.rlast == beatLast));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ID_NUM; i++) begin
        state[i]   <= ENTRY_FREE;
        beatCnt[i] <= '0;
      end
      rreadyQ <= 1'b0;
      errorQ  <= 1'b0;
    end else begin
      rreadyQ <= 1'b1;
      if (beatBad) errorQ <= 1'b1;
      if (doAlloc) state[tail] <= ENTRY_PENDING;
      if (beatOk) begin
        if (beatLast) begin
          state[bus.rid]   <= ENTRY_DONE;
          beatCnt[bus.rid] <= '0;
        end else begin
          state[bus.rid]   <= ENTRY_FILLING;
          beatCnt[bus.rid] <= beatIdx + BEAT_W'(1);
        end
      end
      if (doPop) state[head] <= ENTRY_FREE;
    end
  end

  // Payload storage is deliberately unreset; state alone says what is valid.
  always_ff @(posedge clk) begin
    if (beatOk) entryData[bus.rid][int'(beatIdx)*DW +: DW] <= bus.rdata;
  end

  assign bus.allocAck      = !full;
  assign bus.allocId       = tail;
  assign bus.rready        = rreadyQ;
  assign bus.respValid     = respValid;
  assign bus.respData      = entryData[head];
  assign bus.respId        = head;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.protocolError = errorQ;
endmodule

// File: tb/tb_memory_read_data_queue.sv
// Scoreboard bench: allocated IDs are queued in issue order, beat data is
// modelled per ID, and every delivery is popped and compared.
import memory_read_data_queue_pkg::*;

module tb_memory_read_data_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;

  memory_read_data_queue_if #(.ID_W(2), .DW(64)) bus ();

  memory_read_data_queue #(.ID_NUM(4), .BEAT_NUM(2), .DW(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int           checkCount = 0;
  int           passCount  = 0;
  int           sbQueue[$];
  logic [127:0] modelData [4];
  int           modelBeat [4];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    else
      passCount++;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.allocReq  = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rid       = '0;
    bus.rdata     = '0;
    bus.rlast     = 1'b0;
    bus.respReady = 1'b0;
  endtask

  task automatic allocOne(input string tag, input int expId);
    bus.allocReq = 1'b1;
    checkOutput({tag, "_ack"}, 128'(bus.allocAck), 128'(1));
    checkOutput({tag, "_id"}, 128'(bus.allocId), 128'(expId));
    sbQueue.push_back(expId);
    modelBeat[expId] = 0;
    applyStimulus();
    bus.allocReq = 1'b0;
  endtask

  // Drives one beat for this cycle; only beats the DUT should keep update the model.
  task automatic driveBeat(input int id, input logic [63:0] data, input logic last,
                           input bit good);
    bus.rvalid = 1'b1;
    bus.rid    = 2'(id);
    bus.rdata  = data;
    bus.rlast  = last;
    if (good) begin
      modelData[id][modelBeat[id]*64 +: 64] = data;
      modelBeat[id] = last ? 0 : modelBeat[id] + 1;
    end
  endtask

  task automatic sendBeat(input int id, input logic [63:0] data, input logic last,
                          input bit good);
    driveBeat(id, data, last, good);
    applyStimulus();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
  endtask

  task automatic checkHead(input string tag);
    int expId;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_sbSize"}, 128'(sbQueue.size()), 128'(1));
      return;
    end
    expId = sbQueue[0];
    checkOutput({tag, "_valid"}, 128'(bus.respValid), 128'(1));
    checkOutput({tag, "_id"}, 128'(bus.respId), 128'(expId));
    checkOutput({tag, "_data"}, bus.respData, modelData[expId]);
  endtask

  task automatic checkDelivery(input string tag);
    checkHead(tag);
    if (sbQueue.size() != 0) void'(sbQueue.pop_front());
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_allocAck"}, 128'(bus.allocAck), 128'(1));
    checkOutput({tag, "_allocId"}, 128'(bus.allocId), 128'(0));
    checkOutput({tag, "_full"}, 128'(bus.full), 128'(0));
    checkOutput({tag, "_empty"}, 128'(bus.empty), 128'(1));
    checkOutput({tag, "_respValid"}, 128'(bus.respValid), 128'(0));
    checkOutput({tag, "_rready"}, 128'(bus.rready), 128'(0));
    checkOutput({tag, "_protErr"}, 128'(bus.protocolError), 128'(0));
  endtask

  initial begin
    idleInputs();
    for (int i = 0; i < 4; i++) begin
      modelData[i] = '0;
      modelBeat[i] = 0;
    end
    repeat (3) applyStimulus();
    checkResetValues("rst0");
    rst = 1'b1;
    applyStimulus();
    checkOutput("rreadyUp", 128'(bus.rready), 128'(1));

    for (int i = 0; i < 4; i++) allocOne($sformatf("alloc%0d", i), i);
    checkOutput("fullAfter4", 128'(bus.full), 128'(1));
    bus.allocReq = 1'b1;
    checkOutput("alloc5_ack", 128'(bus.allocAck), 128'(0));
    checkOutput("alloc5_id", 128'(bus.allocId), 128'(0));
    applyStimulus();
    bus.allocReq = 1'b0;
    checkOutput("alloc5_idHeld", 128'(bus.allocId), 128'(0));

    sendBeat(1, 64'hAAAA_0000_0000_000A, 1'b0, 1'b1);
    sendBeat(1, 64'hBBBB_0000_0000_000B, 1'b1, 1'b1);
    checkOutput("id1DoneNoResp", 128'(bus.respValid), 128'(0));
    sendBeat(0, 64'hCCCC_0000_0000_000C, 1'b0, 1'b1);
    checkOutput("id0HalfNoResp", 128'(bus.respValid), 128'(0));
    driveBeat(0, 64'hDDDD_0000_0000_000D, 1'b1, 1'b1);
    checkOutput("noBypass", 128'(bus.respValid), 128'(0));
    applyStimulus();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkHead($sformatf("hold%0d", i));
      applyStimulus();
    end
    bus.respReady = 1'b1;
    checkDelivery("deliver0");
    applyStimulus();
    checkDelivery("deliver1");
    applyStimulus();
    bus.respReady = 1'b0;
    checkOutput("drainedTwo_valid", 128'(bus.respValid), 128'(0));
    checkOutput("drainedTwo_empty", 128'(bus.empty), 128'(0));

    sendBeat(0, 64'hDEAD_BEEF_0000_0000, 1'b1, 1'b0);
    checkOutput("freeBeat_err", 128'(bus.protocolError), 128'(1));
    checkOutput("freeBeat_allocId", 128'(bus.allocId), 128'(0));
    applyStimulus();
    checkOutput("freeBeat_errHeld", 128'(bus.protocolError), 128'(1));

    sendBeat(2, 64'h2222_0000_0000_0002, 1'b0, 1'b1);
    sendBeat(3, 64'h3333_0000_0000_0003, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    checkResetValues("midRst");
    sbQueue.delete();
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("postRst%0d_valid", i), 128'(bus.respValid), 128'(0));
      checkOutput($sformatf("postRst%0d_empty", i), 128'(bus.empty), 128'(1));
      applyStimulus();
    end

    for (int i = 0; i < 4; i++) allocOne($sformatf("realloc%0d", i), i);
    sendBeat(0, 64'hEEEE_0000_0000_000E, 1'b0, 1'b1);
    sendBeat(0, 64'hFFFF_0000_0000_000F, 1'b1, 1'b1);
    bus.allocReq  = 1'b1;
    bus.respReady = 1'b1;
    driveBeat(1, 64'h1111_0000_0000_0001, 1'b0, 1'b1);
    checkOutput("popFull_ack", 128'(bus.allocAck), 128'(0));
    checkDelivery("popFull");
    applyStimulus();
    idleInputs();
    checkOutput("wrap_ack", 128'(bus.allocAck), 128'(1));
    checkOutput("wrap_full", 128'(bus.full), 128'(0));
    checkOutput("wrap_respValid", 128'(bus.respValid), 128'(0));
    allocOne("wrapAlloc", 0);
    checkOutput("wrap_refull", 128'(bus.full), 128'(1));

    sendBeat(1, 64'h0BAD_0000_0000_0000, 1'b0, 1'b0);
    checkOutput("missingLast_err", 128'(bus.protocolError), 128'(1));
    sendBeat(2, 64'h0BAD_0000_0000_0001, 1'b1, 1'b0);
    sendBeat(1, 64'h1111_0000_0000_0011, 1'b1, 1'b1);
    checkOutput("id1AfterErr_valid", 128'(bus.respValid), 128'(1));
    sendBeat(2, 64'h2222_0000_0000_0022, 1'b0, 1'b1);
    sendBeat(2, 64'h2222_0000_0000_0222, 1'b1, 1'b1);
    sendBeat(3, 64'h3333_0000_0000_0033, 1'b0, 1'b1);
    sendBeat(3, 64'h3333_0000_0000_0333, 1'b1, 1'b1);
    sendBeat(0, 64'h4444_0000_0000_0044, 1'b0, 1'b1);
    sendBeat(0, 64'h4444_0000_0000_0444, 1'b1, 1'b1);
    bus.respReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkDelivery($sformatf("final%0d", i));
      applyStimulus();
    end
    bus.respReady = 1'b0;
    checkOutput("finalEmpty", 128'(bus.empty), 128'(1));
    checkOutput("finalNoValid", 128'(bus.respValid), 128'(0));
    checkOutput("finalErrSticky", 128'(bus.protocolError), 128'(1));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
